// File: rtl/servo_pwm_generator_pkg.sv
// servo_pwm_generator_pkg
//   Shared frame/width constants (50 MHz defaults) and the generator state
//   encoding. Used by the PWM generator, the pulse-width measurement block
//   and the Avalon register wrapper so all agree on width units.
package servo_pwm_generator_pkg;

  localparam int unsigned SERVO_CNT_W         = 32;
  localparam int unsigned SERVO_PERIOD_CYCLES = 1_000_000; // 20 ms
  localparam int unsigned SERVO_MIN_WIDTH     = 50_000;    // 1.0 ms
  localparam int unsigned SERVO_MAX_WIDTH     = 100_000;   // 2.0 ms
  localparam int unsigned SERVO_DEFAULT_WIDTH = 75_000;    // 1.5 ms

  // IDLE: line parked low; RUN: free-running frames;
  // DRAIN: enable fell, current frame still completes.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } servo_state_e;

endpackage

// File: rtl/servo_pwm_generator_if.sv
// servo_pwm_generator_if
//   Control/status bundle between the register wrapper (master) and one
//   servo PWM generator (slave).
//   enable, cmd_write, cmd_width            : master -> slave
//   pwm_out, period_start, active_width,
//   pending_valid, clamp_event              : slave -> master
interface servo_pwm_generator_if #(
  parameter int unsigned CNT_W = servo_pwm_generator_pkg::SERVO_CNT_W
);
  logic             enable;
  logic             cmd_write;
  logic [CNT_W-1:0] cmd_width;
  logic             pwm_out;
  logic             period_start;
  logic [CNT_W-1:0] active_width;
  logic             pending_valid;
  logic             clamp_event;

  modport master (
    output enable, cmd_write, cmd_width,
    input  pwm_out, period_start, active_width, pending_valid, clamp_event
  );

  modport slave (
    input  enable, cmd_write, cmd_width,
    output pwm_out, period_start, active_width, pending_valid, clamp_event
  );
endinterface

// File: rtl/servo_pwm_generator_width_clamp.sv
// servo_width_clamp
//   Combinational range limiter: y = x limited to [min, max], unsigned.
//   x_i, min_i, max_i : value and bounds
//   y_o               : limited value
//   clamped_o         : 1 when y_o differs from x_i
module servo_width_clamp #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] min_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] y_o,
  output logic         clamped_o
);

  always_comb begin
    y_o       = x_i;
    clamped_o = 1'b0;
    if (x_i < min_i) begin
      y_o       = min_i;
      clamped_o = 1'b1;
    end else if (x_i > max_i) begin
      y_o       = max_i;
      clamped_o = 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm_generator.sv
// servo_pwm_generator
//   One hobby-servo PWM line: fixed-length frame, high time = commanded width
//   in clocks. New widths are staged and only applied at frame boundaries.
//   clock_clk : system clock
//   reset     : synchronous, active-high
//   bus       : slave side of servo_pwm_generator_if
//     enable        level, 1 = generate frames
//     cmd_write     1-cycle strobe accepting cmd_width (clamped)
//     pwm_out       registered PWM line
//     period_start  1-cycle pulse on the first clock of each frame
//     active_width  width applied to the current frame
//     pending_valid written width waiting for the next frame boundary
//     clamp_event   1-cycle pulse: last accepted write was clamped
module servo_pwm_generator
  import servo_pwm_generator_pkg::*;
#(
  parameter int unsigned CNT_W         = SERVO_CNT_W,
  parameter int unsigned PERIOD_CYCLES = SERVO_PERIOD_CYCLES,
  parameter int unsigned MIN_WIDTH     = SERVO_MIN_WIDTH,
  parameter int unsigned MAX_WIDTH     = SERVO_MAX_WIDTH,
  parameter int unsigned DEFAULT_WIDTH = SERVO_DEFAULT_WIDTH
) (
  input  logic                  clock_clk,
  input  logic                  reset,
  servo_pwm_generator_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] DEF_W    = CNT_W'(DEFAULT_WIDTH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  servo_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, pending_q;
  logic             pending_valid_q, clamp_event_q;
  logic             pwm_q, period_start_q;

  logic [CNT_W-1:0] clamp_y;
  logic             clamp_hit;
  logic             wrap, boundary;

  servo_width_clamp #(.W(CNT_W)) u_clamp (
    .x_i       (bus.cmd_width),
    .min_i     (MIN_W),
    .max_i     (MAX_W),
    .y_o       (clamp_y),
    .clamped_o (clamp_hit)
  );

  // Last clock of a frame; the IDLE->RUN hop also counts as a boundary so
  // the first frame picks up whatever was written while idle.
  assign wrap     = (state_q != ST_IDLE) && (cnt_q == LAST_CNT);
  assign boundary = wrap || ((state_q == ST_IDLE) && bus.enable);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        if (!bus.enable) state_d = wrap ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        // enable coming back mid-drain resumes without breaking the frame
        if (bus.enable) begin
          state_d = ST_RUN;
          cnt_d   = wrap ? '0 : cnt_q + ONE;
        end else if (wrap) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      active_q        <= DEF_W;
      pending_q       <= DEF_W;
      pending_valid_q <= 1'b0;
      clamp_event_q   <= 1'b0;
      pwm_q           <= 1'b0;
      period_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      // MAX < PERIOD guarantees a low tail, so the line never sticks high
      pwm_q          <= (state_q != ST_IDLE) && (cnt_q < active_q);
      period_start_q <= (state_d == ST_RUN) && (cnt_d == '0);
      clamp_event_q  <= bus.cmd_write && clamp_hit;

      if (bus.cmd_write) pending_q <= clamp_y;

      // A write landing on the boundary bypasses staging entirely.
      if (boundary) begin
        active_q        <= bus.cmd_write ? clamp_y : pending_q;
        pending_valid_q <= 1'b0;
      end else if (bus.cmd_write) begin
        pending_valid_q <= 1'b1;
      end
    end
  end

  assign bus.pwm_out       = pwm_q;
  assign bus.period_start  = period_start_q;
  assign bus.active_width  = active_q;
  assign bus.pending_valid = pending_valid_q;
  assign bus.clamp_event   = clamp_event_q;

endmodule
